sc_hdlc_native_tx: RTL and testbench
====================================

# sc_hdlc_native_tx

HDLC bit-level transmit engine that sits on the far side of the native transmit interface from the stream-to-native adapter. It pulls bytes on request, emits opening flag, bit-stuffed payload, optional CRC-16 FCS and closing flag as a serial bitstream. It produces the `tx_input_req`/`tx_busy`/`tx_flag` handshake the adapter consumes, and it consumes `tx_start`/`tx_data`/`tx_empty`.

## Interface
Parameters:
- `BIT_DIV`, 4: clock cycles per serial bit; legal range 2..65535.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `tx_start`  in  1  one-cycle pulse: a frame is available.
- `tx_data`  in  8  next payload byte, sampled one cycle after `tx_input_req`.
- `tx_empty`  in  1  no further payload, sampled with `tx_data`; 1 ends the payload.
- `tx_input_req`  out  1  one-cycle pulse requesting the next byte.
- `tx_busy`  out  1  frame in progress.
- `tx_flag`  out  1  high while flag bits are on `txd`.
- `txd`  out  1  serial line, LSB first; idle mark = 1.
- `tx_bit_en`  out  1  one-cycle strobe marking each new bit on `txd`.

## Operation
- Bit divider free-runs from reset. `tx_bit_en` pulses once every `BIT_DIV` cycles, including during idle. `txd` changes only on `tx_bit_en` cycles.
- FSM states: IDLE → OPEN_FLAG → DATA → FCS → CLOSE_FLAG → IDLE.
- IDLE: `txd`=1. A `tx_start` pulse sets `tx_busy` and arms the start; the frame begins at the next `tx_bit_en`. `tx_start` while `tx_busy`=1 is ignored.
- OPEN_FLAG: shifts 0x7E (bits 0,1,1,1,1,1,1,0) with `tx_flag`=1 and no stuffing. `tx_input_req` pulses on its first bit.
- Byte fetch: on the cycle after each `tx_input_req`, `tx_data`/`tx_empty` are latched into a hold register.
  - `tx_empty`=0: byte queued.
  - `tx_empty`=1: payload ends and the FSM goes to FCS, or to CLOSE_FLAG when the FCS is compiled out. `tx_data` is ignored.
- DATA: the queued byte loads the shift register, LSB first. `tx_input_req` pulses on the first bit of each byte.
- Zero-bit stuffing in DATA and FCS:
  - After five consecutive 1s, insert one 0. The inserted bit is not counted as data.
  - The ones-counter clears on any 0, including a stuffed 0, and at each flag.
  - Stuffing lengthens the byte period. It does not change fetch order.
- FCS: CRC-16/X.25.
  - Reflected polynomial 0x8408, init 0xFFFF, updated per payload bit.
  - Transmitted complemented, low byte first, LSB first.
- CLOSE_FLAG: 0x7E with `tx_flag`=1. `tx_busy` drops on the cycle after the last flag bit ends; the FSM returns to IDLE. Back-to-back frames need a new `tx_start`; no shared flags.
- Empty frame (first fetch returns `tx_empty`=1): open flag, FCS 0x0000, close flag.

## Timing
- Reset values: `txd`=1, `tx_bit_en`=0, `tx_busy`=0, `tx_flag`=0, `tx_input_req`=0, FSM=IDLE, divider=0.
- `tx_start` in cycle N → `tx_busy`=1 in N+1. The first flag bit appears on the next `tx_bit_en` at or after N+1.
- `tx_input_req` in cycle N → sample in N+1. `BIT_DIV`≥2 guarantees the byte is held before the current byte's last bit completes.
- `rst` asserted mid-frame → next cycle all outputs at reset values, the frame is dropped, and no closing flag is sent.
- `tx_start` coincident with `rst`: reset wins.
- `tx_flag` and `tx_busy` change on the `tx_bit_en` cycle of the bit they describe, except the `tx_busy` fall defined above.

## Configuration
- `SC_HDLC_TX_CRC_EN` defined: CRC logic and FCS state are compiled in, and two FCS bytes follow the payload.
- Not defined: no CRC logic, and DATA goes directly to CLOSE_FLAG. Frame = flag, payload, flag.

## Test plan
- Reset/idle, `BIT_DIV`=4: `rst` high 2 cycles → all outputs at reset values. `txd` stays 1 and `tx_bit_en` pulses every 4 cycles for 100 cycles.
- Stuffing, macro off, payload 0xFF:
  - `txd` = 01111110, 11111 0 111, 01111110 (25 bits).
  - `tx_flag` high for exactly 16 bit periods.
- FCS, macro on, payload ASCII "123456789": stuffed bitstream destuffed by the bench model yields the 9 bytes, then 0x6E, 0x90, between flags. `tx_input_req` pulses 10 times.
- Empty frame, macro on: first fetch `tx_empty`=1 → 01111110, sixteen 0s, 01111110 (32 bits). `tx_input_req` pulses once; `tx_busy` width is 32×`BIT_DIV` cycles ±`BIT_DIV` alignment.
- Ignore and abort:
  - Second `tx_start` mid-frame → no effect on the bitstream.
  - `rst` during payload bit 3 → next cycle `txd`=1, `tx_busy`=0, `tx_flag`=0.
  - A new `tx_start` afterwards sends a complete, correct frame.
- Minimum divider, `BIT_DIV`=2, macro off, payload 0xA5, 0x3C: bench supplies each byte exactly one cycle after `tx_input_req` → bitstream flag, A5, 3C, flag, LSB first, no stuffing, 32 bits.

Source files
------------

// File: rtl/sc_hdlc_native_tx.sv
`default_nettype none
// ============================================================================
//  Module      : sc_hdlc_native_tx
//  Description : HDLC bit-level transmit engine. Pulls payload bytes on
//                request and serialises opening flag, bit-stuffed payload,
//                optional CRC-16/X.25 FCS and closing flag, LSB first.
//                Optional FCS is enabled by defining SC_HDLC_TX_CRC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_hdlc_native_tx #(
    parameter int BIT_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_empty,
    output logic       tx_input_req,
    output logic       tx_busy,
    output logic       tx_flag,
    output logic       txd,
    output logic       tx_bit_en
);

    localparam logic [2:0]  c_st_idle  = 3'd0;
    localparam logic [2:0]  c_st_open  = 3'd1;
    localparam logic [2:0]  c_st_data  = 3'd2;
`ifdef SC_HDLC_TX_CRC_EN
    localparam logic [2:0]  c_st_fcs   = 3'd3;
`endif
    localparam logic [2:0]  c_st_close = 3'd4;
    localparam logic [15:0] c_div_last = 16'(BIT_DIV - 1);
    localparam logic [15:0] c_flag     = 16'h007E;

    logic [15:0] r_div;
    logic [2:0]  r_state;
    logic [15:0] r_shift;      // bits still to send, LSB goes out next
    logic [4:0]  r_cnt;        // number of valid bits left in r_shift
    logic [2:0]  r_ones;       // consecutive ones sent in stuffed regions
    logic [7:0]  r_hold_data;
    logic        r_hold_empty;
    logic        r_fetch;
    logic        r_txd;
    logic        r_bit_en;
    logic        r_busy;
    logic        r_flag;
    logic        r_req;
`ifdef SC_HDLC_TX_CRC_EN
    logic [15:0] r_crc;
    logic [15:0] w_crc_next;
    logic        w_crc_init;
`endif

    logic        w_tick;
    logic        w_stuff;
    logic [2:0]  w_state_n;
    logic [15:0] w_shift_n;
    logic [4:0]  w_cnt_n;
    logic        w_req_n;

    assign w_tick = (r_div == c_div_last);

    // Decide what the next bit period carries: a stuffed zero, or the next
    // bit of the current/freshly loaded shift word, plus the state it is in.
    always_comb begin
        w_state_n = r_state;
        w_shift_n = r_shift;
        w_cnt_n   = r_cnt;
        w_req_n   = 1'b0;
`ifdef SC_HDLC_TX_CRC_EN
        w_crc_init = 1'b0;
        w_stuff    = ((r_state == c_st_data) || (r_state == c_st_fcs)) && (r_ones == 3'd5);
`else
        w_stuff    = (r_state == c_st_data) && (r_ones == 3'd5);
`endif
        if (!w_stuff && (r_cnt == 5'd0)) begin
            case (r_state)
                c_st_idle: begin
                    if (r_busy || tx_start) begin
                        w_state_n = c_st_open;
                        w_shift_n = c_flag;
                        w_cnt_n   = 5'd8;
                        w_req_n   = 1'b1;
`ifdef SC_HDLC_TX_CRC_EN
                        w_crc_init = 1'b1;
`endif
                    end
                end
                c_st_open, c_st_data: begin
                    if (r_hold_empty) begin
`ifdef SC_HDLC_TX_CRC_EN
                        w_state_n = c_st_fcs;
                        w_shift_n = ~r_crc;
                        w_cnt_n   = 5'd16;
`else
                        w_state_n = c_st_close;
                        w_shift_n = c_flag;
                        w_cnt_n   = 5'd8;
`endif
                    end else begin
                        w_state_n = c_st_data;
                        w_shift_n = {8'h00, r_hold_data};
                        w_cnt_n   = 5'd8;
                        w_req_n   = 1'b1;
                    end
                end
`ifdef SC_HDLC_TX_CRC_EN
                c_st_fcs: begin
                    w_state_n = c_st_close;
                    w_shift_n = c_flag;
                    w_cnt_n   = 5'd8;
                end
`endif
                c_st_close: begin
                    w_state_n = c_st_idle;
                end
                default: begin
                    w_state_n = c_st_idle;
                end
            endcase
        end
`ifdef SC_HDLC_TX_CRC_EN
        // Reflected CRC step over the payload bit about to be sent
        w_crc_next = {1'b0, r_crc[15:1]} ^ ((r_crc[0] ^ w_shift_n[0]) ? 16'h8408 : 16'h0000);
`endif
    end

    // Bit divider, byte fetch, and the framing FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div        <= '0;
            r_state      <= c_st_idle;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_ones       <= '0;
            r_hold_data  <= '0;
            r_hold_empty <= 1'b0;
            r_fetch      <= 1'b0;
            r_txd        <= 1'b1;
            r_bit_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_flag       <= 1'b0;
            r_req        <= 1'b0;
`ifdef SC_HDLC_TX_CRC_EN
            r_crc        <= 16'hFFFF;
`endif
        end else begin
            r_div    <= w_tick ? 16'd0 : r_div + 16'd1;
            r_bit_en <= w_tick;
            r_req    <= 1'b0;
            r_fetch  <= r_req;
            if (r_fetch) begin
                r_hold_data  <= tx_data;
                r_hold_empty <= tx_empty;
            end
            if ((r_state == c_st_idle) && !r_busy && tx_start)
                r_busy <= 1'b1;
            if (w_tick) begin
                if (w_stuff) begin
                    r_txd  <= 1'b0;
                    r_ones <= 3'd0;
                end else if (w_state_n == c_st_idle) begin
                    r_state <= c_st_idle;
                    r_txd   <= 1'b1;
                    r_flag  <= 1'b0;
                    r_ones  <= 3'd0;
                    if (r_state == c_st_close)
                        r_busy <= 1'b0;
                end else begin
                    r_state <= w_state_n;
                    r_txd   <= w_shift_n[0];
                    r_shift <= {1'b0, w_shift_n[15:1]};
                    r_cnt   <= w_cnt_n - 5'd1;
                    r_req   <= w_req_n;
                    if ((w_state_n == c_st_open) || (w_state_n == c_st_close)) begin
                        r_flag <= 1'b1;
                        r_ones <= 3'd0;
                    end else begin
                        r_flag <= 1'b0;
                        r_ones <= w_shift_n[0] ? r_ones + 3'd1 : 3'd0;
                    end
`ifdef SC_HDLC_TX_CRC_EN
                    if (w_crc_init)
                        r_crc <= 16'hFFFF;
                    else if (w_state_n == c_st_data)
                        r_crc <= w_crc_next;
`endif
                end
            end
        end
    end

    assign txd          = r_txd;
    assign tx_bit_en    = r_bit_en;
    assign tx_busy      = r_busy;
    assign tx_flag      = r_flag;
    assign tx_input_req = r_req;

endmodule
`default_nettype wire

// File: tb/tb_sc_hdlc_native_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_hdlc_native_tx
//  Description : Self-checking bench for sc_hdlc_native_tx (BIT_DIV 4 and 2).
//                Adapts to SC_HDLC_TX_CRC_EN being defined or not.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_hdlc_native_tx;

    typedef struct {
        string       nm;
        int          n;
        logic [79:0] b;
        int          bits_off;
        int          bits_on;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] st  = 2'b00;
    logic [1:0] emp;
    logic [7:0] dat [2];
    wire  [1:0] req;
    wire  [1:0] busy;
    wire  [1:0] flg;
    wire  [1:0] txd;
    wire  [1:0] ben;

    int          checks   = 0;
    int          failures = 0;
    int          nbits [2];
    int          nreq  [2];
    int          nflag [2];
    int          bwid  [2];
    int          pidx  [2];
    int          plen  [2];
    bit          cap   [2];
    bit          reqp  [2];
    logic        bits_q [2][0:1023];
    logic [7:0]  pl    [2][0:15];
    logic [7:0]  dec   [0:15];
    vec_t        vt    [7];

    always #5 clk = ~clk;

    sc_hdlc_native_tx #(.BIT_DIV(4)) u_dut0 (
        .clk(clk), .rst(rst), .tx_start(st[0]), .tx_data(dat[0]), .tx_empty(emp[0]),
        .tx_input_req(req[0]), .tx_busy(busy[0]), .tx_flag(flg[0]), .txd(txd[0]),
        .tx_bit_en(ben[0]));

    sc_hdlc_native_tx #(.BIT_DIV(2)) u_dut1 (
        .clk(clk), .rst(rst), .tx_start(st[1]), .tx_data(dat[1]), .tx_empty(emp[1]),
        .tx_input_req(req[1]), .tx_busy(busy[1]), .tx_flag(flg[1]), .txd(txd[1]),
        .tx_bit_en(ben[1]));

    // Byte source (valid exactly one cycle after a request, junk otherwise) and bit capture
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (reqp[k]) begin
                if (pidx[k] < plen[k]) begin
                    dat[k] = pl[k][pidx[k]];
                    emp[k] = 1'b0;
                end else begin
                    dat[k] = 8'($urandom);
                    emp[k] = 1'b1;
                end
                pidx[k]++;
            end else begin
                dat[k] = 8'($urandom);
                emp[k] = 1'($urandom);
            end
            reqp[k] = req[k];
            if (cap[k]) begin
                if (ben[k] && busy[k] && nbits[k] < 1024) begin
                    bits_q[k][nbits[k]] = txd[k];
                    if (flg[k]) nflag[k]++;
                    nbits[k]++;
                end
                if (req[k])  nreq[k]++;
                if (busy[k]) bwid[k]++;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

`ifdef SC_HDLC_TX_CRC_EN
    function automatic logic [15:0] fcs_of(input logic [79:0] b, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, b[8*i +: 8]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return ~c;
    endfunction
`endif

    task automatic run_frame(input int k, input bit second_start);
        int t;
        @(negedge clk);
        nbits[k] = 0; nreq[k] = 0; nflag[k] = 0; bwid[k] = 0; pidx[k] = 0; cap[k] = 1'b1;
        st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
        chk("busy_after_start", int'(busy[k]), 1);
        t = 0;
        while (busy[k] === 1'b1 && t < 4000) begin
            @(negedge clk);
            t++;
            if (second_start && t == 60) st[k] = 1'b1;
            if (t == 61) st[k] = 1'b0;
        end
        chk("frame_done_in_time", int'(t < 4000), 1);
        @(negedge clk);
        @(negedge clk);
        cap[k] = 1'b0;
    endtask

    task automatic check_frame(input int k, input string nm, input int n,
                               input logic [79:0] b, input int exp_bits);
        logic [7:0] eb [0:15];
        logic [7:0] fo, fc;
        int ne, ones, nd, bad_stuff, mism;
        ne = n;
        for (int i = 0; i < n; i++) eb[i] = b[8*i +: 8];
`ifdef SC_HDLC_TX_CRC_EN
        begin
            logic [15:0] c;
            c = fcs_of(b, n);
            eb[n]   = c[7:0];
            eb[n+1] = c[15:8];
            ne = n + 2;
        end
`endif
        fo = 8'h00; fc = 8'h00;
        if (nbits[k] >= 16) begin
            for (int i = 0; i < 8; i++) begin
                fo[i] = bits_q[k][i];
                fc[i] = bits_q[k][nbits[k] - 8 + i];
            end
        end
        chk({nm, "_open_flag"}, int'(fo), 8'h7E);
        chk({nm, "_close_flag"}, int'(fc), 8'h7E);
        ones = 0; nd = 0; bad_stuff = 0;
        for (int i = 8; i < nbits[k] - 8; i++) begin
            if (ones == 5) begin
                if (bits_q[k][i] !== 1'b0) bad_stuff++;
                ones = 0;
            end else begin
                if (nd < 128) dec[nd / 8][nd % 8] = bits_q[k][i];
                nd++;
                ones = (bits_q[k][i] === 1'b1) ? ones + 1 : 0;
            end
        end
        chk({nm, "_stuffing"}, bad_stuff, 0);
        chk({nm, "_data_bits"}, nd, ne * 8);
        mism = 0;
        for (int i = 0; i < ne && i < 16; i++)
            if (dec[i] !== eb[i]) mism++;
        chk({nm, "_byte_mismatches"}, mism, 0);
        chk({nm, "_flag_bits"}, nflag[k], 16);
        chk({nm, "_req_pulses"}, nreq[k], n + 1);
        if (exp_bits >= 0) chk({nm, "_total_bits"}, nbits[k], exp_bits);
    endtask

    task automatic chk_lit(input int k, input string nm, input string s);
        int mism;
        mism = 0;
        for (int i = 0; i < s.len() && i < nbits[k]; i++)
            if (bits_q[k][i] !== ((s[i] == "1") ? 1'b1 : 1'b0)) mism++;
        chk({nm, "_len"}, nbits[k], s.len());
        chk({nm, "_bit_mismatches"}, mism, 0);
    endtask

    initial begin
        int pulses, last, gapbad, txdbad, t;
        for (int k = 0; k < 2; k++) begin
            cap[k] = 1'b0; reqp[k] = 1'b0; pidx[k] = 0; plen[k] = 0;
            nbits[k] = 0; nreq[k] = 0; nflag[k] = 0; bwid[k] = 0;
        end
        vt[0] = '{"ff",     1, 80'hFF,                 25, -1};
        vt[1] = '{"00_55",  2, 80'h5500,               32, -1};
        vt[2] = '{"7e",     1, 80'h7E,                 25, -1};
        vt[3] = '{"f8_1f",  2, 80'h1FF8,               34, -1};
        vt[4] = '{"a5_3c",  2, 80'h3CA5,               32, -1};
        vt[5] = '{"empty",  0, 80'h0,                  16, 32};
        vt[6] = '{"digits", 9, 80'h393837363534333231, 88, 104};

        // Reset values
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_txd",       int'(txd[0]),  1);
        chk("rst_bit_en",    int'(ben[0]),  0);
        chk("rst_busy",      int'(busy[0]), 0);
        chk("rst_flag",      int'(flg[0]),  0);
        chk("rst_input_req", int'(req[0]),  0);
        rst = 1'b0;

        // Idle: mark level and free-running bit strobe
        pulses = 0; last = -1; gapbad = 0; txdbad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (txd[0] !== 1'b1) txdbad++;
            if (ben[0] === 1'b1) begin
                if (last >= 0 && c - last != 4) gapbad++;
                last = c;
                pulses++;
            end
        end
        chk("idle_txd_not_mark", txdbad, 0);
        chk("idle_bit_en_count", pulses, 25);
        chk("idle_bit_en_gap",   gapbad, 0);

        // Directed frame table on the BIT_DIV=4 instance
        for (int v = 0; v < 7; v++) begin
            plen[0] = vt[v].n;
            for (int i = 0; i < vt[v].n; i++) pl[0][i] = vt[v].b[8*i +: 8];
            run_frame(0, v == 6);
`ifdef SC_HDLC_TX_CRC_EN
            check_frame(0, vt[v].nm, vt[v].n, vt[v].b, vt[v].bits_on);
            if (v == 5) begin
                chk_lit(0, "empty_exact", "01111110000000000000000001111110");
                chk("empty_busy_width_ok", int'(bwid[0] >= 31 * 4 && bwid[0] <= 33 * 4), 1);
            end
            if (v == 6) begin
                chk("digits_fcs_lo", int'(dec[9]),  8'h6E);
                chk("digits_fcs_hi", int'(dec[10]), 8'h90);
            end
`else
            check_frame(0, vt[v].nm, vt[v].n, vt[v].b, vt[v].bits_off);
            if (v == 0) chk_lit(0, "ff_exact", "0111111011111011101111110");
            if (v == 5)
                chk("empty_busy_width_ok", int'(bwid[0] >= 15 * 4 && bwid[0] <= 17 * 4), 1);
`endif
        end

        // Abort: reset during payload bit 3
        plen[0] = 2; pl[0][0] = 8'h00; pl[0][1] = 8'hFF;
        @(negedge clk);
        nbits[0] = 0; nreq[0] = 0; nflag[0] = 0; bwid[0] = 0; pidx[0] = 0; cap[0] = 1'b1;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        t = 0;
        while (nbits[0] < 12 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reached_bit3", int'(t < 2000), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_txd",     int'(txd[0]),  1);
        chk("abort_busy",    int'(busy[0]), 0);
        chk("abort_flag",    int'(flg[0]),  0);
        chk("abort_bit_en",  int'(ben[0]),  0);
        rst = 1'b0;
        cap[0] = 1'b0;
        repeat (5) @(negedge clk);
        plen[0] = 1; pl[0][0] = 8'h3C;
        run_frame(0, 1'b0);
`ifdef SC_HDLC_TX_CRC_EN
        check_frame(0, "after_abort", 1, 80'h3C, -1);
`else
        check_frame(0, "after_abort", 1, 80'h3C, 24);
`endif

        // Minimum divider on the BIT_DIV=2 instance
        plen[1] = 2; pl[1][0] = 8'hA5; pl[1][1] = 8'h3C;
        run_frame(1, 1'b0);
`ifdef SC_HDLC_TX_CRC_EN
        check_frame(1, "div2", 2, 80'h3CA5, -1);
`else
        check_frame(1, "div2", 2, 80'h3CA5, 32);
        chk_lit(1, "div2_exact", "01111110101001010011110001111110");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
